// File: rtl/trigger_capture.sv
// trigger_capture: samples chanSignals into a circular buffer, holds pre-trigger history,
// fires on a masked pattern match and streams the capture out oldest-first over valid/ready.
// Optional macro TRIGGER_CAPTURE_INPUT_SYNC_EN adds a 2-flop synchronizer on chanSignals.
module trigger_capture #(
    parameter int NUM_CHANNELS = 16,
    parameter int ADDR_BITS    = 10,
    parameter int DIV_BITS     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CHANNELS-1:0] chanSignals,
    input  logic                    arm,
    input  logic                    abort,
    input  logic [NUM_CHANNELS-1:0] trigMask,
    input  logic [NUM_CHANNELS-1:0] trigValue,
    input  logic [ADDR_BITS-1:0]    preTrigCount,
    input  logic [DIV_BITS-1:0]     sampleDiv,
    output logic                    armed,
    output logic                    triggered,
    output logic                    done,
    output logic [NUM_CHANNELS-1:0] rdData,
    output logic                    rdValid,
    input  logic                    rdReady,
    output logic                    rdLast
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] DEPTH_W = {1'b1, {ADDR_BITS{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRETRIG,
        S_ARMED,
        S_POST,
        S_DONE
    } state_t;

    state_t                  r_state;
    logic [ADDR_BITS-1:0]    r_wrPtr;
    logic [ADDR_BITS-1:0]    r_count;
    logic [ADDR_BITS-1:0]    r_preTrig;
    logic [ADDR_BITS-1:0]    r_trigAddr;
    logic [ADDR_BITS-1:0]    r_postRem;
    logic [ADDR_BITS-1:0]    r_rdAddr;
    logic [ADDR_BITS:0]      r_rdIssued;
    logic [DIV_BITS-1:0]     r_div;
    logic [DIV_BITS-1:0]     r_sampleDiv;
    logic [NUM_CHANNELS-1:0] r_mem [DEPTH];
    logic [NUM_CHANNELS-1:0] r_ramQ;
    logic                    r_qValid;
    logic                    r_qLast;

    logic [NUM_CHANNELS-1:0] w_sample;
    logic                    w_capturing;
    logic                    w_strobe;
    logic                    w_match;
    logic                    w_we;
    logic                    w_outLoad;
    logic                    w_issue;
    logic                    w_lastXfer;

`ifdef TRIGGER_CAPTURE_INPUT_SYNC_EN
    logic [NUM_CHANNELS-1:0] r_sync1;
    logic [NUM_CHANNELS-1:0] r_sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= chanSignals;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sample = r_sync2;
`else
    assign w_sample = chanSignals;
`endif

    assign w_capturing = (r_state == S_PRETRIG) || (r_state == S_ARMED) || (r_state == S_POST);
    assign w_strobe    = w_capturing && (r_div == r_sampleDiv);
    assign w_match     = ((w_sample ^ trigValue) & trigMask) == '0;
    // With no pre-trigger history requested, PRETRIG only lasts one cycle and stores nothing.
    assign w_we        = w_strobe && !((r_state == S_PRETRIG) && (r_preTrig == '0));

    // Two-stage read pipeline (RAM register, output register); each stage advances
    // when the stage after it is empty or being drained, so there are no bubbles.
    assign w_outLoad  = !rdValid || rdReady;
    assign w_issue    = (r_state == S_DONE) && (r_rdIssued != DEPTH_W) && (!r_qValid || w_outLoad);
    assign w_lastXfer = rdValid && rdReady && rdLast;

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_wrPtr] <= w_sample;
        end
        if (w_issue) begin
            r_ramQ <= r_mem[r_rdAddr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wrPtr     <= '0;
            r_count     <= '0;
            r_preTrig   <= '0;
            r_trigAddr  <= '0;
            r_postRem   <= '0;
            r_rdAddr    <= '0;
            r_rdIssued  <= '0;
            r_div       <= '0;
            r_sampleDiv <= '0;
            r_qValid    <= 1'b0;
            r_qLast     <= 1'b0;
            armed       <= 1'b0;
            triggered   <= 1'b0;
            done        <= 1'b0;
            rdValid     <= 1'b0;
            rdLast      <= 1'b0;
            rdData      <= '0;
        end else if (abort) begin
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_qValid  <= 1'b0;
            r_qLast   <= 1'b0;
            armed     <= 1'b0;
            triggered <= 1'b0;
            done      <= 1'b0;
            rdValid   <= 1'b0;
            rdLast    <= 1'b0;
            rdData    <= '0;
        end else if (arm && ((r_state == S_IDLE) || (r_state == S_DONE))) begin
            // preTrigCount is ADDR_BITS wide, so it is already bounded to DEPTH-1.
            r_state     <= S_PRETRIG;
            r_wrPtr     <= '0;
            r_count     <= '0;
            r_div       <= '0;
            r_preTrig   <= preTrigCount;
            r_sampleDiv <= sampleDiv;
            r_qValid    <= 1'b0;
            r_qLast     <= 1'b0;
            armed       <= 1'b1;
            triggered   <= 1'b0;
            done        <= 1'b0;
            rdValid     <= 1'b0;
            rdLast      <= 1'b0;
            rdData      <= '0;
        end else begin
            if (w_capturing) begin
                r_div <= w_strobe ? '0 : r_div + 1'b1;
            end
            case (r_state)
                S_PRETRIG: begin
                    if (r_preTrig == '0) begin
                        r_state <= S_ARMED;
                    end else if (w_strobe) begin
                        r_wrPtr <= r_wrPtr + 1'b1;
                        r_count <= r_count + 1'b1;
                        if (r_count == r_preTrig - 1'b1) begin
                            r_state <= S_ARMED;
                        end
                    end
                end
                S_ARMED: begin
                    if (w_strobe) begin
                        r_wrPtr <= r_wrPtr + 1'b1;
                        if (w_match) begin
                            r_trigAddr <= r_wrPtr;
                            r_postRem  <= ~r_preTrig;  // DEPTH-1-preTrig
                            triggered  <= 1'b1;
                            armed      <= 1'b0;
                            if (r_preTrig == '1) begin
                                r_state    <= S_DONE;
                                done       <= 1'b1;
                                r_rdAddr   <= r_wrPtr - r_preTrig;
                                r_rdIssued <= '0;
                            end else begin
                                r_state <= S_POST;
                            end
                        end
                    end
                end
                S_POST: begin
                    if (w_strobe) begin
                        r_wrPtr   <= r_wrPtr + 1'b1;
                        r_postRem <= r_postRem - 1'b1;
                        if (r_postRem == {{(ADDR_BITS-1){1'b0}}, 1'b1}) begin
                            r_state    <= S_DONE;
                            done       <= 1'b1;
                            r_rdAddr   <= r_trigAddr - r_preTrig;
                            r_rdIssued <= '0;
                        end
                    end
                end
                S_DONE: begin
                    if (w_issue) begin
                        r_rdAddr   <= r_rdAddr + 1'b1;
                        r_rdIssued <= r_rdIssued + 1'b1;
                        r_qValid   <= 1'b1;
                        r_qLast    <= (r_rdIssued[ADDR_BITS-1:0] == '1);
                    end else if (w_outLoad) begin
                        r_qValid <= 1'b0;
                    end
                    if (w_lastXfer) begin
                        r_state   <= S_IDLE;
                        r_qValid  <= 1'b0;
                        r_qLast   <= 1'b0;
                        done      <= 1'b0;
                        triggered <= 1'b0;
                        rdValid   <= 1'b0;
                        rdLast    <= 1'b0;
                        rdData    <= '0;
                    end else if (w_outLoad) begin
                        rdValid <= r_qValid;
                        rdLast  <= r_qValid && r_qLast;
                        if (r_qValid) begin
                            rdData <= r_ramQ;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
